// File: rtl/pwl_sweep_pkg.sv
// Shared types for the PWL sweep engine: step modes, write field codes, cfg bit map, FSM states.
package pwl_sweep_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_SAT      = 2'd1,
    MODE_WRAP     = 2'd2,
    MODE_PINGPONG = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    FIELD_PERIOD = 2'd0,
    FIELD_AMP    = 2'd1,
    FIELD_CFG    = 2'd2,
    FIELD_CTL    = 2'd3
  } field_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  localparam int CFG_BITS       = 16;
  localparam int CFG_RATE_LSB   = 0;
  localparam int CFG_STEP_LSB   = 8;
  localparam int CFG_STEP_BITS  = 4;
  localparam int CFG_TARGET_BIT = 12;
  localparam int CFG_DIR_BIT    = 13;
  localparam int CFG_MODE_LSB   = 14;

endpackage

// File: rtl/pwl_sweep_engine_if.sv
// Register-write bus into the sweep engine and the per-channel update stream out of it.
interface pwl_sweep_engine_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int PERIOD_BITS  = 13,
  parameter int AMP_BITS     = 6
);
  localparam int CH_BITS = $clog2(NUM_CHANNELS);

  logic                   wr_en;
  logic [CH_BITS+1:0]     wr_addr;
  logic [15:0]            wr_data;
  logic                   upd_valid;
  logic [CH_BITS-1:0]     upd_channel;
  logic [PERIOD_BITS-1:0] upd_period;
  logic [AMP_BITS-1:0]    upd_amp;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  upd_valid, upd_channel, upd_period, upd_amp
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output upd_valid, upd_channel, upd_period, upd_amp
  );

endinterface

// File: rtl/pwl_sweep_step.sv
// Combinational step unit: applies +/-delta to a W-bit value under saturate, wrap or ping-pong rules.
module pwl_sweep_step
  import pwl_sweep_pkg::*;
#(
  parameter int W = 6
) (
  input  logic [W-1:0]             value,
  input  logic [CFG_STEP_BITS-1:0] delta,
  input  logic                     dir,
  input  mode_e                    mode,
  output logic [W-1:0]             new_value,
  output logic                     dir_flip
);
  logic [W:0]   delta_x;
  logic [W:0]   sum;
  logic [W:0]   diff;
  logic [W-1:0] raw;
  logic [W-1:0] bound;
  logic         out_of_range;

  // One extra bit catches both overflow (up) and borrow (down).
  assign delta_x      = (W+1)'(delta);
  assign sum          = {1'b0, value} + delta_x;
  assign diff         = {1'b0, value} - delta_x;
  assign raw          = dir ? diff[W-1:0] : sum[W-1:0];
  assign out_of_range = dir ? diff[W] : sum[W];
  assign bound        = dir ? '0 : '1;

  always_comb begin
    new_value = value;
    dir_flip  = 1'b0;
    unique case (mode)
      MODE_SAT:      new_value = out_of_range ? bound : raw;
      MODE_WRAP:     new_value = raw;
      MODE_PINGPONG: begin
        new_value = out_of_range ? bound : raw;
        dir_flip  = out_of_range;
      end
      MODE_OFF:      new_value = value;
    endcase
  end

endmodule

// File: rtl/pwl_sweep_engine.sv
// Time-multiplexed per-channel period/amp sweeper: a tick scans all channels one per clock, update registered.
// Tick in cycle t gives channel k's update in cycle t+1+k; writes are never stalled, one extra tick is queued.
module pwl_sweep_engine
  import pwl_sweep_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int PERIOD_BITS  = 13,
  parameter int AMP_BITS     = 6,
  parameter int RATE_BITS    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_in,
  pwl_sweep_engine_if.slave bus,
  output logic              busy,
  output logic              overrun
);
  localparam int CH_BITS = $clog2(NUM_CHANNELS);

  logic [PERIOD_BITS-1:0] period_q [NUM_CHANNELS];
  logic [AMP_BITS-1:0]    amp_q    [NUM_CHANNELS];
  logic [CFG_BITS-1:0]    cfg_q    [NUM_CHANNELS];
  logic [RATE_BITS-1:0]   cnt_q    [NUM_CHANNELS];

  state_e               state_q, state_d;
  logic [CH_BITS-1:0]   ch_q, ch_d;
  logic                 pending_q, pending_d;
  logic                 overrun_q, overrun_d;
  logic                 upd_valid_q;
  logic [CH_BITS-1:0]   upd_channel_q;
  logic [PERIOD_BITS-1:0] upd_period_q;
  logic [AMP_BITS-1:0]  upd_amp_q;

  logic [CH_BITS-1:0]   wr_ch;
  field_e               wr_field;
  logic                 wr_ok;
  logic                 visit_en;

  assign wr_ch    = bus.wr_addr[CH_BITS+1:2];
  assign wr_field = field_e'(bus.wr_addr[1:0]);
  assign wr_ok    = bus.wr_en && (int'(wr_ch) < NUM_CHANNELS);

  // The channel entering SCAN this edge (ch_d) is the one computed now, so its update lands with busy.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (bus.wr_en && wr_field == FIELD_CTL) overrun_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tick_in || pending_q) begin
          state_d   = ST_SCAN;
          ch_d      = '0;
          pending_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (ch_q == CH_BITS'(NUM_CHANNELS - 1)) begin
          if (pending_q || tick_in) begin
            ch_d      = '0;
            pending_d = 1'b0;
            if (pending_q && tick_in) overrun_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          ch_d = ch_q + 1'b1;
          if (tick_in) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
          end
        end
      end
    endcase
  end

  assign visit_en = (state_d == ST_SCAN);

  logic [CFG_BITS-1:0]      cfg_v;
  logic [RATE_BITS-1:0]     rate_v, cnt_v;
  logic [CFG_STEP_BITS-1:0] step_v;
  logic                     target_amp, dir_v, active;
  mode_e                    mode_v;
  logic [PERIOD_BITS-1:0]   per_step;
  logic [AMP_BITS-1:0]      amp_step;
  logic                     per_flip, amp_flip;

  assign cfg_v      = cfg_q[ch_d];
  assign cnt_v      = cnt_q[ch_d];
  assign rate_v     = cfg_v[CFG_RATE_LSB +: RATE_BITS];
  assign step_v     = cfg_v[CFG_STEP_LSB +: CFG_STEP_BITS];
  assign target_amp = cfg_v[CFG_TARGET_BIT];
  assign dir_v      = cfg_v[CFG_DIR_BIT];
  assign mode_v     = mode_e'(cfg_v[CFG_MODE_LSB +: 2]);
  assign active     = (mode_v != MODE_OFF) && (rate_v != '0);

  pwl_sweep_step #(.W(PERIOD_BITS)) u_step_period (
    .value(period_q[ch_d]), .delta(step_v), .dir(dir_v), .mode(mode_v),
    .new_value(per_step), .dir_flip(per_flip)
  );

  pwl_sweep_step #(.W(AMP_BITS)) u_step_amp (
    .value(amp_q[ch_d]), .delta(step_v), .dir(dir_v), .mode(mode_v),
    .new_value(amp_step), .dir_flip(amp_flip)
  );

  logic [PERIOD_BITS-1:0] per_nxt;
  logic [AMP_BITS-1:0]    amp_nxt;
  logic [CFG_BITS-1:0]    cfg_nxt;
  logic [RATE_BITS-1:0]   cnt_nxt;
  logic                   wr_hit, kill_step;

  // A same-cycle write to the swept field replaces the whole step result, dir flip included.
  always_comb begin
    per_nxt   = period_q[ch_d];
    amp_nxt   = amp_q[ch_d];
    cfg_nxt   = cfg_v;
    cnt_nxt   = cnt_v;
    wr_hit    = wr_ok && (wr_ch == ch_d);
    kill_step = wr_hit && ((wr_field == FIELD_PERIOD && !target_amp) ||
                           (wr_field == FIELD_AMP && target_amp));
    if (active) begin
      cnt_nxt = (cnt_v == '0) ? rate_v - 1'b1 : cnt_v - 1'b1;
      if (cnt_v == '0 && !kill_step) begin
        if (target_amp) begin
          amp_nxt = amp_step;
          if (amp_flip) cfg_nxt[CFG_DIR_BIT] = ~dir_v;
        end else begin
          per_nxt = per_step;
          if (per_flip) cfg_nxt[CFG_DIR_BIT] = ~dir_v;
        end
      end
    end
    if (wr_hit) begin
      unique case (wr_field)
        FIELD_PERIOD: per_nxt = bus.wr_data[PERIOD_BITS-1:0];
        FIELD_AMP:    amp_nxt = bus.wr_data[AMP_BITS-1:0];
        FIELD_CFG: begin
          cfg_nxt = bus.wr_data;
          cnt_nxt = '0;
        end
        FIELD_CTL:    cnt_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ch_q          <= '0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      upd_valid_q   <= 1'b0;
      upd_channel_q <= '0;
      upd_period_q  <= '0;
      upd_amp_q     <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        period_q[i] <= '0;
        amp_q[i]    <= '0;
        cfg_q[i]    <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      if (wr_ok) begin
        unique case (wr_field)
          FIELD_PERIOD: period_q[wr_ch] <= bus.wr_data[PERIOD_BITS-1:0];
          FIELD_AMP:    amp_q[wr_ch]    <= bus.wr_data[AMP_BITS-1:0];
          FIELD_CFG: begin
            cfg_q[wr_ch] <= bus.wr_data;
            cnt_q[wr_ch] <= '0;
          end
          FIELD_CTL:    cnt_q[wr_ch]    <= '0;
        endcase
      end
      if (visit_en) begin
        period_q[ch_d] <= per_nxt;
        amp_q[ch_d]    <= amp_nxt;
        cfg_q[ch_d]    <= cfg_nxt;
        cnt_q[ch_d]    <= cnt_nxt;
        upd_channel_q  <= ch_d;
        upd_period_q   <= per_nxt;
        upd_amp_q      <= amp_nxt;
      end
      upd_valid_q <= visit_en;
    end
  end

  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_channel = upd_channel_q;
  assign bus.upd_period  = upd_period_q;
  assign bus.upd_amp     = upd_amp_q;
  assign busy            = (state_q == ST_SCAN);
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_pwl_sweep_engine.sv
// Directed bench for pwl_sweep_engine: hand-computed sweep results per tick, overrun and write collision.
module tb_pwl_sweep_engine;
  import pwl_sweep_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic tick_in;
  logic busy;
  logic overrun;

  pwl_sweep_engine_if #(.NUM_CHANNELS(N)) bus ();

  pwl_sweep_engine #(.NUM_CHANNELS(N)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .bus(bus), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] s_vld [N];
  logic [31:0] s_ch  [N];
  logic [31:0] s_per [N];
  logic [31:0] s_amp [N];
  logic [31:0] s_bsy [N];
  logic [31:0] s_vld_after, s_bsy_after;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk_cfg(input int rate, input int step, input bit target,
                                         input bit dir, input mode_e mode);
    logic [15:0] c;
    c        = '0;
    c[7:0]   = rate[7:0];
    c[11:8]  = step[3:0];
    c[12]    = target;
    c[13]    = dir;
    c[15:14] = mode;
    return c;
  endfunction

  task automatic wr(input int ch, input field_e f, input logic [15:0] d);
    @(posedge clk); #1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = {2'(ch), 2'(f)};
    bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en   = 1'b0;
  endtask

  task automatic tick_scan();
    @(posedge clk); #1;
    tick_in = 1'b1;
    @(posedge clk); #1;
    tick_in = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      s_vld[k] = 32'(bus.upd_valid);
      s_ch[k]  = 32'(bus.upd_channel);
      s_per[k] = 32'(bus.upd_period);
      s_amp[k] = 32'(bus.upd_amp);
      s_bsy[k] = 32'(busy);
    end
    @(negedge clk);
    s_vld_after = 32'(bus.upd_valid);
    s_bsy_after = 32'(busy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_per [5];
  logic [31:0] o_vld [11];
  logic [31:0] o_ch  [11];
  int          run;

  initial begin
    rst         = 1'b1;
    tick_in     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", 32'(bus.upd_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_per", 32'(bus.upd_period), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // First scan after reset: all channels report zeros, busy for exactly N cycles.
    tick_scan();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("scan0_vld%0d", k), s_vld[k], 1);
      chk($sformatf("scan0_ch%0d", k), s_ch[k], k);
      chk($sformatf("scan0_per%0d", k), s_per[k], 0);
      chk($sformatf("scan0_amp%0d", k), s_amp[k], 0);
      chk($sformatf("scan0_busy%0d", k), s_bsy[k], 1);
    end
    chk("scan0_vld_end", s_vld_after, 0);
    chk("scan0_busy_end", s_bsy_after, 0);
    chk("scan0_ovr", 32'(overrun), 0);

    // Rate 2 saturate on ch1 period.
    wr(1, FIELD_PERIOD, 16'd100);
    wr(1, FIELD_CFG, mk_cfg(2, 5, 1'b0, 1'b0, MODE_SAT));
    exp_per = '{105, 105, 110, 110, 115};
    for (int t = 0; t < 5; t++) begin
      tick_scan();
      chk($sformatf("rate_per_t%0d", t + 1), s_per[1], exp_per[t]);
    end

    // Saturate amp up, then down.
    wr(0, FIELD_AMP, 16'd60);
    wr(0, FIELD_CFG, mk_cfg(1, 5, 1'b1, 1'b0, MODE_SAT));
    tick_scan();
    chk("sat_up_t1", s_amp[0], 63);
    tick_scan();
    chk("sat_up_t2", s_amp[0], 63);
    wr(0, FIELD_AMP, 16'd2);
    wr(0, FIELD_CFG, mk_cfg(1, 5, 1'b1, 1'b1, MODE_SAT));
    tick_scan();
    chk("sat_dn_t1", s_amp[0], 0);
    tick_scan();
    chk("sat_dn_t2", s_amp[0], 0);

    // Wrap on ch2, ping-pong on ch3.
    wr(2, FIELD_AMP, 16'd62);
    wr(2, FIELD_CFG, mk_cfg(1, 3, 1'b1, 1'b0, MODE_WRAP));
    wr(3, FIELD_AMP, 16'd2);
    wr(3, FIELD_CFG, mk_cfg(1, 3, 1'b1, 1'b1, MODE_PINGPONG));
    tick_scan();
    chk("wrap_t1", s_amp[2], 1);
    chk("pp_t1", s_amp[3], 0);
    tick_scan();
    chk("wrap_t2", s_amp[2], 4);
    chk("pp_t2", s_amp[3], 3);

    // Three back-to-back ticks: one queued rescan, one dropped.
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      tick_in = (c < 3);
      @(negedge clk);
      o_vld[c] = 32'(bus.upd_valid);
      o_ch[c]  = 32'(bus.upd_channel);
    end
    tick_in = 1'b0;
    run = 0;
    for (int c = 0; c < 11; c++) begin
      if (o_vld[c] == 1) run++;
      chk($sformatf("ovr_vld_c%0d", c), o_vld[c], (c >= 1 && c <= 8) ? 1 : 0);
      if (c >= 1 && c <= 8) chk($sformatf("ovr_ch_c%0d", c), o_ch[c], (c - 1) % N);
    end
    chk("ovr_run", run, 8);
    chk("ovr_set", 32'(overrun), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ovr_sticky", 32'(overrun), 1);
    wr(1, FIELD_CTL, 16'hFFFF);
    @(negedge clk);
    chk("ovr_clear", 32'(overrun), 0);

    // Write to ch2 amp in the cycle ch2's update is being computed.
    wr(2, FIELD_AMP, 16'd10);
    wr(2, FIELD_CFG, mk_cfg(1, 1, 1'b1, 1'b0, MODE_WRAP));
    @(posedge clk); #1;
    tick_in = 1'b1;
    @(posedge clk); #1;
    tick_in = 1'b0;
    @(posedge clk); #1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = {2'd2, 2'(FIELD_AMP)};
    bus.wr_data = 16'd40;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    @(negedge clk);
    chk("coll_vld", 32'(bus.upd_valid), 1);
    chk("coll_ch", 32'(bus.upd_channel), 2);
    chk("coll_amp", 32'(bus.upd_amp), 40);
    repeat (3) @(posedge clk);
    tick_scan();
    chk("coll_next", s_amp[2], 41);

    // Reset in the middle of a scan aborts it.
    @(posedge clk); #1;
    tick_in = 1'b1;
    @(posedge clk); #1;
    tick_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("abort_vld%0d", c), 32'(bus.upd_valid), 0);
      chk($sformatf("abort_busy%0d", c), 32'(busy), 0);
    end
    chk("abort_amp", 32'(bus.upd_amp), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
